bcd_double_dabble: RTL

//   Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_add3_nibble.sv | 13 +
 rtl/bcd_double_dabble.sv | 115 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
// Holds the double-dabble nibble constants, the converter state encoding and
// the 7-segment digit table used by the per-digit HexDisplay decoders.
package bcd_pkg;

  localparam int         BCD_NIBBLE_W   = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0] ADD3_VALUE     = 4'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-decimal codes blank.
  function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
    logic [6:0] seg;
    seg = 7'b111_1111;
    case (digit)
      4'd0: seg = 7'b100_0000;
      4'd1: seg = 7'b111_1001;
      4'd2: seg = 7'b010_0100;
      4'd3: seg = 7'b011_0000;
      4'd4: seg = 7'b001_1001;
      4'd5: seg = 7'b001_0010;
      4'd6: seg = 7'b000_0010;
      4'd7: seg = 7'b111_1000;
      4'd8: seg = 7'b000_0000;
      4'd9: seg = 7'b001_0000;
      default: seg = 7'b111_1111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction cell: adds 3 to a BCD nibble holding 5 or more.
// Purely combinational, zero latency; no flow control.
// Ports: nib_i (4-bit nibble in), nib_o (corrected nibble out, carry discarded).
module bcd_add3_nibble
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nib_i,
  output logic [BCD_NIBBLE_W-1:0] nib_o
);

  assign nib_o = (nib_i >= ADD3_THRESHOLD) ? (nib_i + ADD3_VALUE) : nib_i;

endmodule

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Latency WIDTH cycles from Start accept to the Valid pulse; Busy high meanwhile.
// Ports: Clock/Reset (async active-low), Start+Bin request, Busy, Valid pulse,
//        Bcd (packed, [3:0]=ones) and Overflow held until the next completion.
//        Start while Busy is dropped, not queued.
module bcd_double_dabble
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [WIDTH-1:0]         Bin,
  output logic                     Busy,
  output logic                     Valid,
  output logic [4*DIGITS-1:0]      Bcd,
  output logic                     Overflow
);

  localparam int BW = BCD_NIBBLE_W * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e          state_q,   state_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            valid_q,   valid_d;
  logic [BW-1:0]   bcd_q,     bcd_d;
  logic            ovf_q,     ovf_d;
  // Running overflow for the conversion in flight; copied to ovf_q on completion
  // so the visible flag only changes together with Bcd.
  logic            ovf_acc_q, ovf_acc_d;

  logic [BW-1:0]   adj_bcd;
  logic [SW-1:0]   adjusted;
  logic [SW-1:0]   shifted;
  logic            shift_out;

  // BCD field sits above the binary field in the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .nib_i (scratch_q[WIDTH + BCD_NIBBLE_W*g +: BCD_NIBBLE_W]),
      .nib_o (adj_bcd[BCD_NIBBLE_W*g +: BCD_NIBBLE_W])
    );
  end

  assign adjusted  = {adj_bcd, scratch_q[WIDTH-1:0]};
  assign shifted   = {adjusted[SW-2:0], 1'b0};
  // Bit leaving the top nibble: any 1 here means the value needs more digits.
  assign shift_out = adjusted[SW-1];

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    ovf_acc_d = ovf_acc_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          scratch_d = {{BW{1'b0}}, Bin};
          cnt_d     = CNT_LOAD;
          ovf_acc_d = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = shifted;
        cnt_d     = cnt_q - CNT_ONE;
        ovf_acc_d = ovf_acc_q | shift_out;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          bcd_d   = shifted[SW-1 -: BW];
          ovf_d   = ovf_acc_q | shift_out;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end

  assign Busy     = (state_q == ST_SHIFT);
  assign Valid    = valid_q;
  assign Bcd      = bcd_q;
  assign Overflow = ovf_q;

endmodule
